// File: rtl/maq_pkg.sv
// Shared BCD types, constants and the binary-to-BCD helper for the clock datapath.
package maq_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t msd;
        bcd_digit_t lsd;
    } bcd_pair_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic bcd_pair_t to_bcd(input int value);
        bcd_pair_t pair;
        pair.msd = 4'(value / 10);
        pair.lsd = 4'(value % 10);
        return pair;
    endfunction

endpackage

// File: rtl/maq_bcd_mod_if.sv
// Request/preset/result bundle of a two-digit BCD modulo counter stage.
interface maq_bcd_mod_if;
    import maq_pkg::*;

    logic       maqbcd_enable;
    logic       maqbcd_incremento;
    logic       maqbcd_decremento;
    logic       maqbcd_load;
    bcd_digit_t maqbcd_load_lsd;
    bcd_digit_t maqbcd_load_msd;
    bcd_digit_t maqbcd_lsd;
    bcd_digit_t maqbcd_msd;
    logic       maqbcd_carry;
    logic       maqbcd_borrow;
    logic       maqbcd_load_err;

    modport master (
        output maqbcd_enable, maqbcd_incremento, maqbcd_decremento,
               maqbcd_load, maqbcd_load_lsd, maqbcd_load_msd,
        input  maqbcd_lsd, maqbcd_msd, maqbcd_carry, maqbcd_borrow, maqbcd_load_err
    );

    modport slave (
        input  maqbcd_enable, maqbcd_incremento, maqbcd_decremento,
               maqbcd_load, maqbcd_load_lsd, maqbcd_load_msd,
        output maqbcd_lsd, maqbcd_msd, maqbcd_carry, maqbcd_borrow, maqbcd_load_err
    );

endinterface

// File: rtl/maq_bcd_digit.sv
// Single BCD digit next-value logic; wraps 9->0 / 0->9 locally, range limits live in the parent.
module maq_bcd_digit
    import maq_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t next_val,
    output logic       at_9,
    output logic       at_0
);

    assign at_9 = (digit == BCD_MAX_DIGIT);
    assign at_0 = (digit == 4'd0);

    always_comb begin
        next_val = digit;
        if (load) begin
            next_val = load_val;
        end else if (inc) begin
            next_val = at_9 ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            next_val = at_0 ? BCD_MAX_DIGIT : digit - 4'd1;
        end
    end

endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter MIN_VAL..MAX_VAL with preset and registered wrap pulses.
// Down-counting and the borrow pulse exist only when MAQ_BCD_DOWN_EN is defined.
module maq_bcd_mod
    import maq_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23
) (
    input  logic          maqbcd_clock,
    input  logic          maqbcd_reset,
    maq_bcd_mod_if.slave  bus
);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 99)) begin : g_bad_range
        $error("maq_bcd_mod: require 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    localparam bcd_pair_t MIN_BCD = to_bcd(MIN_VAL);
    localparam bcd_pair_t MAX_BCD = to_bcd(MAX_VAL);

    bcd_digit_t lsd_q, msd_q, lsd_d, msd_d, lsd_nx, msd_nx;
    logic       carry_q, borrow_q, err_q, carry_d, borrow_d;
    logic       do_inc, do_dec, do_load, load_rej, load_ok;
    logic       at_max, at_min;
    logic       lsd_at9, lsd_at0, msd_at9_unused, msd_at0_unused;
    logic [7:0] ld_val;

    // Wrap decisions use the full two-digit value so 19->20 and 12->01 come out right.
    assign at_max = ({msd_q, lsd_q} == MAX_BCD);
    assign at_min = ({msd_q, lsd_q} == MIN_BCD);

    assign ld_val  = {4'd0, bus.maqbcd_load_msd} * 8'd10 + {4'd0, bus.maqbcd_load_lsd};
    assign load_ok = (bus.maqbcd_load_lsd <= BCD_MAX_DIGIT) && (bus.maqbcd_load_msd <= BCD_MAX_DIGIT)
                  && (int'(ld_val) >= MIN_VAL) && (int'(ld_val) <= MAX_VAL);

    assign do_load  = bus.maqbcd_enable & bus.maqbcd_load & load_ok;
    assign load_rej = bus.maqbcd_enable & bus.maqbcd_load & ~load_ok;

`ifdef MAQ_BCD_DOWN_EN
    assign do_inc = bus.maqbcd_enable & ~bus.maqbcd_load & bus.maqbcd_incremento & ~bus.maqbcd_decremento;
    assign do_dec = bus.maqbcd_enable & ~bus.maqbcd_load & bus.maqbcd_decremento & ~bus.maqbcd_incremento;
`else
    logic dec_unused;
    assign dec_unused = bus.maqbcd_decremento;
    assign do_inc = bus.maqbcd_enable & ~bus.maqbcd_load & bus.maqbcd_incremento;
    assign do_dec = 1'b0;
`endif

    maq_bcd_digit u_lsd (
        .digit    (lsd_q),
        .inc      (do_inc),
        .dec      (do_dec),
        .load     (do_load),
        .load_val (bus.maqbcd_load_lsd),
        .next_val (lsd_nx),
        .at_9     (lsd_at9),
        .at_0     (lsd_at0)
    );

    maq_bcd_digit u_msd (
        .digit    (msd_q),
        .inc      (do_inc & lsd_at9),
        .dec      (do_dec & lsd_at0),
        .load     (do_load),
        .load_val (bus.maqbcd_load_msd),
        .next_val (msd_nx),
        .at_9     (msd_at9_unused),
        .at_0     (msd_at0_unused)
    );

    always_comb begin
        lsd_d    = lsd_nx;
        msd_d    = msd_nx;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (do_inc && at_max) begin
            {msd_d, lsd_d} = MIN_BCD;
            carry_d        = 1'b1;
        end else if (do_dec && at_min) begin
            {msd_d, lsd_d} = MAX_BCD;
            borrow_d       = 1'b1;
        end
    end

    always_ff @(posedge maqbcd_clock or posedge maqbcd_reset) begin
        if (maqbcd_reset) begin
            lsd_q    <= MIN_BCD.lsd;
            msd_q    <= MIN_BCD.msd;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lsd_q    <= lsd_d;
            msd_q    <= msd_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= load_rej;
        end
    end

    assign bus.maqbcd_lsd      = lsd_q;
    assign bus.maqbcd_msd      = msd_q;
    assign bus.maqbcd_carry    = carry_q;
    assign bus.maqbcd_borrow   = borrow_q;
    assign bus.maqbcd_load_err = err_q;

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Directed bench for maq_bcd_mod: three stages (0-23, 1-12, 0-59) sharing clock and reset.
module tb_maq_bcd_mod;
    import maq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    maq_bcd_mod_if b23 ();
    maq_bcd_mod_if b12 ();
    maq_bcd_mod_if b59 ();

    maq_bcd_mod #(.MIN_VAL(0), .MAX_VAL(23)) u23 (.maqbcd_clock(clk), .maqbcd_reset(rst), .bus(b23));
    maq_bcd_mod #(.MIN_VAL(1), .MAX_VAL(12)) u12 (.maqbcd_clock(clk), .maqbcd_reset(rst), .bus(b12));
    maq_bcd_mod #(.MIN_VAL(0), .MAX_VAL(59)) u59 (.maqbcd_clock(clk), .maqbcd_reset(rst), .bus(b59));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b23.maqbcd_enable = 1'b0; b23.maqbcd_incremento = 1'b0; b23.maqbcd_decremento = 1'b0;
        b23.maqbcd_load = 1'b0;   b23.maqbcd_load_lsd = 4'd0;   b23.maqbcd_load_msd = 4'd0;
        b12.maqbcd_enable = 1'b0; b12.maqbcd_incremento = 1'b0; b12.maqbcd_decremento = 1'b0;
        b12.maqbcd_load = 1'b0;   b12.maqbcd_load_lsd = 4'd0;   b12.maqbcd_load_msd = 4'd0;
        b59.maqbcd_enable = 1'b0; b59.maqbcd_incremento = 1'b0; b59.maqbcd_decremento = 1'b0;
        b59.maqbcd_load = 1'b0;   b59.maqbcd_load_lsd = 4'd0;   b59.maqbcd_load_msd = 4'd0;

        #1 rst = 1'b1;
        step();
        chk("rst_u23_val", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h00);
        chk("rst_u12_val", {b12.maqbcd_msd, b12.maqbcd_lsd}, 8'h01);
        chk("rst_u59_val", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);
        chk("rst_pulses", {b23.maqbcd_carry, b23.maqbcd_borrow, b23.maqbcd_load_err,
                           b12.maqbcd_carry, b12.maqbcd_borrow, b12.maqbcd_load_err}, 8'h00);
        rst = 1'b0;

        // 24 increments on 0-23 and 1-12 in parallel
        b23.maqbcd_enable = 1'b1; b23.maqbcd_incremento = 1'b1;
        b12.maqbcd_enable = 1'b1; b12.maqbcd_incremento = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            chk("u23_count", {b23.maqbcd_msd, b23.maqbcd_lsd}, to_bcd(i % 24));
            chk("u23_carry", b23.maqbcd_carry, 8'(i == 24));
            chk("u12_count", {b12.maqbcd_msd, b12.maqbcd_lsd}, to_bcd(1 + i % 12));
            chk("u12_carry", b12.maqbcd_carry, 8'(i % 12 == 0));
        end
        b23.maqbcd_incremento = 1'b0; b12.maqbcd_incremento = 1'b0;
        step();
        chk("u23_carry_drop", b23.maqbcd_carry, 8'd0);
        chk("u23_hold", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h00);
        chk("u12_hold", {b12.maqbcd_msd, b12.maqbcd_lsd}, 8'h01);

        // presets: 59 accepted on 0-59, 00 rejected on 1-12
        b59.maqbcd_enable = 1'b1; b59.maqbcd_load = 1'b1;
        b59.maqbcd_load_msd = 4'd5; b59.maqbcd_load_lsd = 4'd9;
        b12.maqbcd_load = 1'b1; b12.maqbcd_load_msd = 4'd0; b12.maqbcd_load_lsd = 4'd0;
        step();
        chk("u59_load59", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h59);
        chk("u59_load59_err", b59.maqbcd_load_err, 8'd0);
        chk("u12_load00_held", {b12.maqbcd_msd, b12.maqbcd_lsd}, 8'h01);
        chk("u12_load00_err", b12.maqbcd_load_err, 8'd1);
        b12.maqbcd_load = 1'b0;
        b59.maqbcd_load = 1'b0; b59.maqbcd_incremento = 1'b1;
        step();
        chk("u59_wrap", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);
        chk("u59_wrap_carry", b59.maqbcd_carry, 8'd1);
        chk("u12_err_drop", b12.maqbcd_load_err, 8'd0);
        b59.maqbcd_incremento = 1'b0; b59.maqbcd_load = 1'b1;
        b59.maqbcd_load_msd = 4'd6; b59.maqbcd_load_lsd = 4'd0;
        step();
        chk("u59_load60_held", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);
        chk("u59_load60_err", b59.maqbcd_load_err, 8'd1);
        chk("u59_load60_carry", b59.maqbcd_carry, 8'd0);
        b59.maqbcd_load = 1'b0;
        step();
        chk("u59_err_drop", b59.maqbcd_load_err, 8'd0);
        b59.maqbcd_load = 1'b1; b59.maqbcd_load_msd = 4'hA; b59.maqbcd_load_lsd = 4'd3;
        step();
        chk("u59_loadA3_held", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);
        chk("u59_loadA3_err", b59.maqbcd_load_err, 8'd1);
        b59.maqbcd_load_msd = 4'd3; b59.maqbcd_load_lsd = 4'd7;
        step();
        chk("u59_load37", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h37);
        chk("u59_load37_err", b59.maqbcd_load_err, 8'd0);
        b59.maqbcd_load = 1'b0;

        // enable low gates both increment and load
        b23.maqbcd_enable = 1'b0; b23.maqbcd_incremento = 1'b1;
        b23.maqbcd_load = 1'b1; b23.maqbcd_load_msd = 4'd1; b23.maqbcd_load_lsd = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("u23_disabled_val", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h00);
            chk("u23_disabled_pulses", {b23.maqbcd_carry, b23.maqbcd_load_err}, 8'd0);
        end
        b23.maqbcd_enable = 1'b1; b23.maqbcd_incremento = 1'b0; b23.maqbcd_load = 1'b0;

`ifdef MAQ_BCD_DOWN_EN
        b23.maqbcd_decremento = 1'b1;
        step();
        chk("u23_dec_wrap", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h23);
        chk("u23_dec_borrow", b23.maqbcd_borrow, 8'd1);
        b23.maqbcd_decremento = 1'b0; b23.maqbcd_load = 1'b1;
        b23.maqbcd_load_msd = 4'd1; b23.maqbcd_load_lsd = 4'd0;
        step();
        chk("u23_load10", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h10);
        chk("u23_borrow_drop", b23.maqbcd_borrow, 8'd0);
        b23.maqbcd_load = 1'b0; b23.maqbcd_decremento = 1'b1;
        step();
        chk("u23_dec_10_09", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h09);
        chk("u23_dec_no_borrow", b23.maqbcd_borrow, 8'd0);
        b23.maqbcd_incremento = 1'b1;
        step();
        chk("u23_incdec_hold", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h09);
        chk("u23_incdec_pulses", {b23.maqbcd_carry, b23.maqbcd_borrow}, 8'd0);
`else
        b23.maqbcd_decremento = 1'b1;
        step();
        chk("u23_dec_ignored", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h00);
        chk("u23_borrow_tied", b23.maqbcd_borrow, 8'd0);
        b23.maqbcd_incremento = 1'b1;
        step();
        chk("u23_incdec_inc", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h01);
        step();
        chk("u23_incdec_inc2", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h02);
        chk("u23_borrow_tied2", b23.maqbcd_borrow, 8'd0);
`endif
        b23.maqbcd_incremento = 1'b0; b23.maqbcd_decremento = 1'b0;

        // asynchronous reset between edges, with a carry pulse pending on 0-59
        b23.maqbcd_load = 1'b1; b23.maqbcd_load_msd = 4'd1; b23.maqbcd_load_lsd = 4'd7;
        b59.maqbcd_load = 1'b1; b59.maqbcd_load_msd = 4'd5; b59.maqbcd_load_lsd = 4'd9;
        step();
        chk("u23_load17", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h17);
        b23.maqbcd_load = 1'b0;
        b59.maqbcd_load = 1'b0; b59.maqbcd_incremento = 1'b1;
        step();
        chk("u59_pending_carry", b59.maqbcd_carry, 8'd1);
        b23.maqbcd_incremento = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_u23", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h00);
        chk("async_rst_u59_carry", b59.maqbcd_carry, 8'd0);
        chk("async_rst_u59_val", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);
        rst = 1'b0;
        b59.maqbcd_incremento = 1'b0;
        step();
        chk("resume_u23", {b23.maqbcd_msd, b23.maqbcd_lsd}, 8'h01);
        chk("resume_u23_carry", b23.maqbcd_carry, 8'd0);
        chk("resume_u59_hold", {b59.maqbcd_msd, b59.maqbcd_lsd}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
